// File: rtl/fetch_buffer.sv
// Circular instruction buffer between the 4-wide fetch port and decode stage 1.
// Oldest four entries are presented combinationally; decode consumes 0..4 per cycle.
module fetch_buffer #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [15:0]   in_pc,
    input  logic [63:0]   in_instr,
    input  logic [2:0]    in_count,
    output logic          in_ready,
    output logic [3:0]    out_valid,
    output logic [63:0]   out_instr,
    output logic [63:0]   out_pc,
    input  logic [2:0]    out_take,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Each entry is {pc, instr}
    logic [31:0] entry_q [DEPTH];
    logic [31:0] entry_d [DEPTH];

    logic [2:0]       in_count_clamped;
    logic [2:0]       push_n;
    logic [2:0]       pop_n;
    logic [DEPTH-1:0] wr_en;
    logic [31:0]      wr_data [DEPTH];

    // Readiness is judged on the pre-pop occupancy so fetch never depends on decode this cycle.
    assign in_ready = (count_q <= CW'(DEPTH - 4));

    always_comb begin
        in_count_clamped = (in_count > 3'd4) ? 3'd4 : in_count;
        push_n           = 3'd0;
        if (in_valid && in_ready && !flush) begin
            push_n = in_count_clamped;
        end
    end

    always_comb begin
        pop_n = out_take;
        if (CW'(out_take) > count_q) begin
            pop_n = count_q[2:0];
        end
    end

    // Write-port decode: entry gi receives group slot (gi - tail) when that slot is being pushed.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
            logic [AW-1:0] offset;
            logic [1:0]    slot;
            assign offset      = AW'(gi) - tail_q;
            assign slot        = offset[1:0];
            assign wr_en[gi]   = (offset < AW'(push_n));
            assign wr_data[gi] = {16'(in_pc + {13'd0, slot, 1'b0}), in_instr[16*slot +: 16]};
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (wr_en[i]) begin
                entry_d[i] = wr_data[i];
            end
        end
    end

    always_comb begin
        head_d  = head_q + AW'(pop_n);
        tail_d  = tail_q + AW'(push_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; contents past the occupancy are don't-care.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out
            logic [AW-1:0] rd_idx;
            assign rd_idx                = head_q + AW'(gi);
            assign out_instr[16*gi +: 16] = entry_q[rd_idx][15:0];
            assign out_pc[16*gi +: 16]    = entry_q[rd_idx][31:16];
            assign out_valid[gi]         = (count_q > CW'(gi));
        end
    endgenerate

    assign count = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [63:0] in_instr;
    logic [2:0]  in_count;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic [63:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  out_take;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_q [$];   // {pc, instr}, oldest at index 0

    fetch_buffer #(.DEPTH(16), .CW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_count  (in_count),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_take  (out_take),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] gen_instr(input logic [15:0] pc);
        logic [63:0] g;
        for (int k = 0; k < 4; k++) begin
            g[16*k +: 16] = 16'(pc + 16'(2*k)) ^ 16'h5A5A;
        end
        return g;
    endfunction

    // Reference model: a plain FIFO of {pc, instr}.
    always @(posedge clk) begin
        int sz;
        int pn;
        int tn;
        sz = model_q.size();
        if (reset || flush) begin
            model_q.delete();
        end else begin
            pn = 0;
            if (in_valid && (16 - sz >= 4)) pn = (in_count > 3'd4) ? 4 : int'(in_count);
            tn = (int'(out_take) < sz) ? int'(out_take) : sz;
            for (int k = 0; k < tn; k++) void'(model_q.pop_front());
            for (int k = 0; k < pn; k++)
                model_q.push_back({16'(in_pc + 16'(2*k)), in_instr[16*k +: 16]});
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int n;
        logic [3:0] ev;
        if (!reset) begin
            n = model_q.size();
            ev = 4'b0000;
            for (int k = 0; k < 4; k++) ev[k] = (n > k);
            chk("model_count", 64'(count), 64'(n));
            chk("model_in_ready", 64'(in_ready), 64'(16 - n >= 4));
            chk("model_out_valid", 64'(out_valid), 64'(ev));
            for (int k = 0; k < 4 && k < n; k++) begin
                chk("model_out_pc", 64'(out_pc[16*k +: 16]), 64'(model_q[k][31:16]));
                chk("model_out_instr", 64'(out_instr[16*k +: 16]), 64'(model_q[k][15:0]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [63:0] ins,
                         input logic [2:0] cnt, input logic [2:0] take, input logic fl);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
        in_count = cnt;
        out_take = take;
        flush    = fl;
    endtask

    initial begin
        logic [15:0] fetch_pc;
        logic [15:0] exp_pop;
        int          npop;
        logic        accept;

        // 1: reset
        reset = 1'b1;
        drive(0, 16'h0, 64'h0, 3'd0, 3'd0, 0);
        tick();
        tick();
        reset = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // 2: first full group
        drive(1, 16'h0000, 64'h4444_3333_2222_1111, 3'd4, 3'd0, 0);
        tick();
        chk("t2_out_valid", 64'(out_valid), 64'hF);
        chk("t2_instr0", 64'(out_instr[15:0]), 64'h1111);
        chk("t2_pc3", 64'(out_pc[63:48]), 64'h0006);
        chk("t2_count", 64'(count), 64'd4);

        // 3: fill to full, hold a group against back-pressure
        for (int g = 1; g < 4; g++) begin
            drive(1, 16'(8*g), gen_instr(16'(8*g)), 3'd4, 3'd0, 0);
            tick();
        end
        chk("t3_full_count", 64'(count), 64'd16);
        chk("t3_full_ready", 64'(in_ready), 64'd0);
        drive(1, 16'h0020, gen_instr(16'h0020), 3'd4, 3'd0, 0);
        tick();
        tick();
        chk("t3_held_count", 64'(count), 64'd16);
        drive(1, 16'h0020, gen_instr(16'h0020), 3'd4, 3'd4, 0);
        tick();
        chk("t3_take_count", 64'(count), 64'd12);
        chk("t3_take_ready", 64'(in_ready), 64'd1);
        chk("t3_take_pc0", 64'(out_pc[15:0]), 64'h0008);
        drive(1, 16'h0020, gen_instr(16'h0020), 3'd4, 3'd0, 0);
        tick();
        chk("t3_accept_count", 64'(count), 64'd16);
        drive(0, 16'h0, 64'h0, 3'd0, 3'd4, 0);
        tick();
        tick();
        tick();
        chk("t3_drain_pc0", 64'(out_pc[15:0]), 64'h0020);
        chk("t3_drain_instr3", 64'(out_instr[63:48]), 64'(16'h0026 ^ 16'h5A5A));
        tick();
        chk("t3_empty_valid", 64'(out_valid), 64'h0);

        // 5: take clamp and partial push
        drive(1, 16'h0080, gen_instr(16'h0080), 3'd2, 3'd0, 0);
        tick();
        chk("t5_count2", 64'(count), 64'd2);
        drive(0, 16'h0, 64'h0, 3'd0, 3'd4, 0);
        tick();
        chk("t5_clamp_count", 64'(count), 64'd0);
        chk("t5_clamp_valid", 64'(out_valid), 64'h0);
        drive(1, 16'h0100, gen_instr(16'h0100), 3'd3, 3'd0, 0);
        tick();
        chk("t5_partial_valid", 64'(out_valid), 64'h7);
        chk("t5_partial_pc2", 64'(out_pc[47:32]), 64'h0104);

        // 6: flush beats same-cycle push and pop
        drive(0, 16'h0, 64'h0, 3'd0, 3'd0, 1);
        tick();
        chk("t6_flush_count", 64'(count), 64'd0);
        for (int g = 0; g < 3; g++) begin
            drive(1, 16'(16'h0200 + 16'(8*g)), gen_instr(16'(16'h0200 + 16'(8*g))), 3'd4, 3'd0, 0);
            tick();
        end
        chk("t6_count12", 64'(count), 64'd12);
        drive(1, 16'h0300, gen_instr(16'h0300), 3'd4, 3'd4, 1);
        tick();
        chk("t6_flush_count2", 64'(count), 64'd0);
        chk("t6_flush_valid", 64'(out_valid), 64'h0);
        drive(1, 16'h0040, gen_instr(16'h0040), 3'd7, 3'd0, 0);
        tick();
        chk("t6_post_pc0", 64'(out_pc[15:0]), 64'h0040);
        chk("t6_post_pc3", 64'(out_pc[63:48]), 64'h0046);
        chk("t6_count_clamp7", 64'(count), 64'd4);

        // 4: steady push 4 / take 3 across index wrap and PC wrap
        drive(0, 16'h0, 64'h0, 3'd0, 3'd0, 1);
        tick();
        fetch_pc = 16'hFFC0;
        exp_pop  = 16'hFFC0;
        for (int c = 0; c < 20; c++) begin
            if (c < 12) drive(1, fetch_pc, gen_instr(fetch_pc), 3'd4, 3'd3, 0);
            else        drive(0, 16'h0, 64'h0, 3'd0, 3'd4, 0);
            accept = (c < 12) && (16 - model_q.size() >= 4);
            npop   = (c < 12) ? 3 : 4;
            if (npop > model_q.size()) npop = model_q.size();
            for (int k = 0; k < npop; k++) begin
                chk("t4_pop_pc", 64'(out_pc[16*k +: 16]), 64'(exp_pop));
                exp_pop = exp_pop + 16'd2;
            end
            tick();
            if (accept) fetch_pc = fetch_pc + 16'd8;
        end
        chk("t4_final_count", 64'(count), 64'd0);
        chk("t4_all_popped", 64'(exp_pop), 64'(fetch_pc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
